clint: RTL

Core-local interruptor: traps ECALL, EBREAK and the external interrupt, and handles the MRET return sequence. It sits between the execute stage and the CSR file. It decodes the instruction in execute and stalls the pipeline while a trap or return is in progress. It writes MEPC, MSTATUS and MCAUSE in order through the CSR file's clint write port, then issues a one-cycle redirect to `mtvec` on a trap or to `mepc` on a return.

---
 rtl/clint_pkg.sv | 23 ++
 rtl/clint.sv | 133 +++++++++++++
 2 files changed

// File: rtl/clint_pkg.sv
// Shared constants for the core-local interruptor: bus widths, CSR addresses,
// system instruction encodings, trap causes and MSTATUS bit positions.
package clint_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_REG_DATA = 32;

    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/clint.sv
// Core-local interruptor: takes ECALL/EBREAK/external-interrupt traps and MRET,
// sequencing MEPC/MSTATUS/MCAUSE writes before a one-cycle redirect.
module clint
    import clint_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INST_REG_DATA-1:0] inst_i,
    input  logic [INST_ADDR_BUS-1:0] inst_addr_i,
    input  logic                     jump_flag_i,
    input  logic [INST_ADDR_BUS-1:0] jump_addr_i,
    input  logic                     irq_i,
    input  logic [INST_REG_DATA-1:0] csr_mtvec_i,
    input  logic [INST_REG_DATA-1:0] csr_mepc_i,
    input  logic [INST_REG_DATA-1:0] csr_mstatus_i,
    output logic                     clint_wr_en_o,
    output logic [INST_ADDR_BUS-1:0] clint_wr_addr_o,
    output logic [INST_REG_DATA-1:0] clint_wr_data_o,
    output logic                     hold_flag_o,
    output logic                     int_assert_o,
    output logic [INST_ADDR_BUS-1:0] int_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_MEPC         = 3'd1,
        S_MSTATUS      = 3'd2,
        S_MCAUSE       = 3'd3,
        S_ASSERT       = 3'd4,
        S_MRET_MSTATUS = 3'd5,
        S_MRET_ASSERT  = 3'd6
    } state_e;

    state_e                   state_q, state_d;
    logic [INST_REG_DATA-1:0] cause_q, cause_d;
    logic [INST_ADDR_BUS-1:0] epc_q, epc_d;

    logic is_ecall, is_ebreak, is_mret, irq_en;

    // Decoding is suppressed while reset is asserted so hold stays low too.
    assign is_ecall  = !rst && (inst_i == INST_ECALL);
    assign is_ebreak = !rst && (inst_i == INST_EBREAK);
    assign is_mret   = !rst && (inst_i == INST_MRET);
    assign irq_en    = !rst && irq_i && csr_mstatus_i[MSTATUS_MIE];

    always_comb begin
        state_d         = state_q;
        cause_d         = cause_q;
        epc_d           = epc_q;
        clint_wr_en_o   = 1'b0;
        clint_wr_addr_o = '0;
        clint_wr_data_o = '0;
        hold_flag_o     = 1'b1;
        int_assert_o    = 1'b0;
        int_addr_o      = '0;

        case (state_q)
            S_IDLE: begin
                hold_flag_o = 1'b0;
                if (is_ecall || is_ebreak) begin
                    hold_flag_o = 1'b1;
                    cause_d     = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                    epc_d       = inst_addr_i;
                    state_d     = S_MEPC;
                end else if (is_mret) begin
                    hold_flag_o = 1'b1;
                    state_d     = S_MRET_MSTATUS;
                end else if (irq_en) begin
                    // Interrupt return must resume at the pending redirect target.
                    hold_flag_o = 1'b1;
                    cause_d     = CAUSE_EXT_IRQ;
                    epc_d       = jump_flag_i ? jump_addr_i : inst_addr_i;
                    state_d     = S_MEPC;
                end
            end
            S_MEPC: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = CSR_MEPC;
                clint_wr_data_o = epc_q;
                state_d         = S_MSTATUS;
            end
            S_MSTATUS: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = CSR_MSTATUS;
                clint_wr_data_o = csr_mstatus_i;
                clint_wr_data_o[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
                clint_wr_data_o[MSTATUS_MIE]  = 1'b0;
                state_d         = S_MCAUSE;
            end
            S_MCAUSE: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = CSR_MCAUSE;
                clint_wr_data_o = cause_q;
                state_d         = S_ASSERT;
            end
            S_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mtvec_i;
                state_d      = S_IDLE;
            end
            S_MRET_MSTATUS: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = CSR_MSTATUS;
                clint_wr_data_o = csr_mstatus_i;
                clint_wr_data_o[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
                clint_wr_data_o[MSTATUS_MPIE] = 1'b1;
                state_d         = S_MRET_ASSERT;
            end
            S_MRET_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc_i;
                state_d      = S_IDLE;
            end
            default: begin
                hold_flag_o = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

endmodule
